// File: rtl/quad_gen.sv
// Quadrature step generator: emits a programmable number of A/B transitions
// at a fixed clock spacing, tracking a signed position count.
module quad_gen #(
  parameter int unsigned PW = 8,
  parameter int unsigned SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dir,
  input  logic [SW-1:0] steps,
  input  logic [PW-1:0] period,
  input  logic          abort,
  output logic          a,
  output logic          b,
  output logic          busy,
  output logic          done,
  output logic [7:0]    pos
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic          dir_q, dir_nx;
  logic [SW-1:0] left_q, left_nx;
  logic [PW-1:0] per_q, per_nx;
  logic [PW-1:0] tmr_q, tmr_nx;
  logic          a_nx, b_nx, done_nx;
  logic [7:0]    pos_nx;
  logic          step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      dir_q  <= 1'b0;
      left_q <= '0;
      per_q  <= '0;
      tmr_q  <= '0;
      a      <= 1'b0;
      b      <= 1'b0;
      done   <= 1'b0;
      pos    <= '0;
    end else begin
      state  <= state_nx;
      dir_q  <= dir_nx;
      left_q <= left_nx;
      per_q  <= per_nx;
      tmr_q  <= tmr_nx;
      a      <= a_nx;
      b      <= b_nx;
      done   <= done_nx;
      pos    <= pos_nx;
    end
  end

  always_comb begin
    state_nx = state;
    dir_nx   = dir_q;
    left_nx  = left_q;
    per_nx   = per_q;
    tmr_nx   = tmr_q;
    a_nx     = a;
    b_nx     = b;
    pos_nx   = pos;
    done_nx  = 1'b0;
    step     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          dir_nx  = dir;
          left_nx = steps;
          per_nx  = (period == '0) ? PW'(1) : period;
          tmr_nx  = '0;
          if (steps == '0) done_nx  = 1'b1;
          else             state_nx = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else if (tmr_q == per_q - PW'(1)) begin
          step    = 1'b1;
          tmr_nx  = '0;
          left_nx = left_q - SW'(1);
          if (left_q == SW'(1)) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end else begin
          tmr_nx = tmr_q + PW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    // Gray step: forward toggles B when A==B, else A; reverse is the mirror.
    if (step) begin
      if (dir_q == (a == b)) b_nx = ~b;
      else                   a_nx = ~a;
      pos_nx = dir_q ? pos + 8'd1 : pos - 8'd1;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_quad_gen.sv
// Directed table-driven bench for quad_gen with a per-cycle reference model
// and a free-running quadrature/position/done checker.
module tb_quad_gen;

  logic       clk, rst, start, dir, abort;
  logic [7:0] steps, period;
  logic       a, b, busy, done;
  logic [7:0] pos;

  quad_gen #(.PW(8), .SW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .steps(steps),
    .period(period), .abort(abort), .a(a), .b(b), .busy(busy),
    .done(done), .pos(pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       dir;
    logic [7:0] steps;
    logic [7:0] period;
    int         abort_at;
    bit         mid_start;
    bit         rst_before;
    logic [1:0] ab;
    logic [7:0] pos;
  } vec_t;

  localparam int NV = 9;
  vec_t tbl [NV];

  logic [1:0] seq [4];
  int         idx;
  logic [7:0] mpos;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic d);
    if (d) begin idx = (idx + 1) % 4; mpos = mpos + 8'd1; end
    else   begin idx = (idx + 3) % 4; mpos = mpos - 8'd1; end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    chk("reset_outputs", {a, b, busy, done, pos}, 12'h000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idx = 0;
    mpos = 8'h00;
  endtask

  task automatic do_move(input logic d, input logic [7:0] st, input logic [7:0] pr,
                         input int ab_at, input bit mid);
    int eff, fin;
    eff = (pr == 8'd0) ? 1 : int'(pr);
    fin = (ab_at != 0) ? ab_at : int'(st) * eff;
    start = 1'b1; dir = d; steps = st; period = pr;
    @(posedge clk); #1;
    start = 1'b0; dir = ~d; steps = ~st; period = 8'd1;
    for (int n = 0; n <= fin + 1; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        if ((ab_at == 0 || n < ab_at) && (n % eff == 0) && (n / eff <= int'(st)))
          model_step(d);
      end
      chk("ab",   {30'd0, a, b}, {30'd0, seq[idx]});
      chk("pos",  {24'd0, pos},  {24'd0, mpos});
      chk("busy", {31'd0, busy}, {31'd0, n < fin});
      chk("done", {31'd0, done}, {31'd0, n == fin});
      if (ab_at != 0 && n == ab_at - 1) abort = 1'b1;
      if (ab_at != 0 && n == ab_at)     abort = 1'b0;
      if (mid && n == 1) begin start = 1'b1; dir = ~d; steps = 8'd1; period = 8'd1; end
      if (mid && n == 2) start = 1'b0;
    end
  endtask

  // Free-running checker: one-bit gray moves, pos tracks transitions, done is a pulse.
  logic       pv = 1'b0;
  logic       pa, pb, pdone;
  logic [7:0] ppos;
  always @(negedge clk) begin
    if (!rst) pv = 1'b0;
    else begin
      if (pv) begin
        int tog;
        logic [7:0] dl;
        logic ok;
        tog = int'(a ^ pa) + int'(b ^ pb);
        dl  = pos - ppos;
        ok  = (tog == 0) ? (dl == 8'd0) : (tog == 1 && (dl == 8'd1 || dl == 8'hFF));
        total++;
        if (!ok || (done && pdone)) begin
          bad++;
          $display("FAIL monitor at %0t: ab %b%b->%b%b pos %0h->%0h done %b->%b",
                   $time, pa, pb, a, b, ppos, pos, pdone, done);
        end
      end
      pa = a; pb = b; ppos = pos; pdone = done; pv = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
    //          dir   steps   period ab_at mid   rst   ab     pos
    tbl[0] = '{1'b1, 8'd4,   8'd3,  0,    1'b0, 1'b1, 2'b00, 8'h04};
    tbl[1] = '{1'b0, 8'd6,   8'd1,  0,    1'b0, 1'b0, 2'b11, 8'hFE};
    tbl[2] = '{1'b1, 8'd0,   8'd5,  0,    1'b0, 1'b0, 2'b11, 8'hFE};
    tbl[3] = '{1'b1, 8'd3,   8'd2,  0,    1'b1, 1'b0, 2'b01, 8'h01};
    tbl[4] = '{1'b1, 8'd255, 8'd0,  0,    1'b0, 1'b1, 2'b10, 8'hFF};
    tbl[5] = '{1'b1, 8'd2,   8'd0,  0,    1'b0, 1'b0, 2'b01, 8'h01};
    tbl[6] = '{1'b1, 8'd8,   8'd4,  10,   1'b0, 1'b1, 2'b11, 8'h02};
    tbl[7] = '{1'b0, 8'd2,   8'd2,  0,    1'b0, 1'b0, 2'b00, 8'h00};
    tbl[8] = '{1'b0, 8'd1,   8'd2,  0,    1'b0, 1'b0, 2'b10, 8'hFF};

    start = 1'b0; dir = 1'b0; steps = 8'd0; period = 8'd0; abort = 1'b0;
    idx = 0; mpos = 8'h00;
    apply_reset();

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].rst_before) apply_reset();
      do_move(tbl[i].dir, tbl[i].steps, tbl[i].period, tbl[i].abort_at, tbl[i].mid_start);
      chk("final_ab",  {30'd0, a, b}, {30'd0, tbl[i].ab});
      chk("final_pos", {24'd0, pos},  {24'd0, tbl[i].pos});
    end

    // abort together with start while idle: nothing happens
    abort = 1'b1; start = 1'b1; dir = 1'b1; steps = 8'd3; period = 8'd1;
    @(posedge clk); #1;
    chk("idle_abort_busy", {31'd0, busy}, 32'd0);
    chk("idle_abort_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_abort_hold", {a, b, done, pos}, {1'b1, 1'b0, 1'b0, 8'hFF});
    abort = 1'b0;

    // reset mid-move: immediate clear, no done, start accepted on first edge
    start = 1'b1; dir = 1'b1; steps = 8'd10; period = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset", {a, b, busy, done, pos}, 12'h000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("reset_no_done", {31'd0, done}, 32'd0);
    end
    rst = 1'b1; idx = 0; mpos = 8'h00;
    do_move(1'b1, 8'd1, 8'd1, 0, 1'b0);
    chk("post_reset_move", {a, b, pos}, {2'b01, 8'h01});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
